// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_hazard_reg
// Description : ID/EX pipeline register for the 5-stage MIPS core with
//               load-use hazard detection, bubble insertion, branch flush
//               and downstream hold. Drives the PC / IF-ID write enables.
//               Optional macro HAZ_STAT_EN adds saturating stall/flush
//               statistics counters (o_stall_cnt, o_flush_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard_reg #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [RW-1:0] i_Rs,
    input  logic [RW-1:0] i_Rt,
    input  logic [RW-1:0] i_Rd,
    input  logic          i_uses_rs,
    input  logic          i_uses_rt,
    input  logic [DW-1:0] i_Read_data1,
    input  logic [DW-1:0] i_Read_data2,
    input  logic [DW-1:0] i_Imm,
    input  logic          i_RegWrite,
    input  logic          i_MemRead,
    input  logic          i_MemWrite,
    input  logic          i_MemtoReg,
    input  logic          i_ALUSrc,
    input  logic          i_RegDst,
    input  logic [1:0]    i_ALUOp,
    input  logic          i_flush,
    input  logic          i_hold,
    output logic          o_valid,
    output logic [RW-1:0] o_Rs,
    output logic [RW-1:0] o_Rt,
    output logic [RW-1:0] o_Write_reg,
    output logic [DW-1:0] o_Read_data1,
    output logic [DW-1:0] o_Read_data2,
    output logic [DW-1:0] o_Imm,
    output logic          o_RegWrite,
    output logic          o_MemRead,
    output logic          o_MemWrite,
    output logic          o_MemtoReg,
    output logic          o_ALUSrc,
    output logic [1:0]    o_ALUOp,
    output logic          o_stall,
    output logic          o_PCWrite,
    output logic          o_IFIDWrite
`ifdef HAZ_STAT_EN
    ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
`endif
);

    // EX-stage state
    logic          r_valid;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_write_reg;
    logic [DW-1:0] r_read_data1;
    logic [DW-1:0] r_read_data2;
    logic [DW-1:0] r_imm;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_mem_to_reg;
    logic          r_alu_src;
    logic [1:0]    r_alu_op;

    logic          w_rs_hit;
    logic          w_rt_hit;
    logic          w_load_use;
    logic          w_stall;
    logic          w_bubble;
    logic          w_upstream_we;

    // Hazard detection: a load in EX whose destination (never $0) is read by ID
    always_comb begin
        w_rs_hit      = i_uses_rs && (i_Rs == r_write_reg);
        w_rt_hit      = i_uses_rt && (i_Rt == r_write_reg);
        w_load_use    = r_valid && r_mem_read && (r_write_reg != '0) && i_valid
                        && (w_rs_hit || w_rt_hit);
        // Hold outranks everything; flush squashes ID so its hazard is moot
        w_stall       = !i_hold && !i_flush && w_load_use;
        w_bubble      = i_flush || w_load_use;
        w_upstream_we = !i_hold && !w_stall;
    end

    // ID/EX register: hold freezes, flush/load-use insert a bubble, else capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_write_reg  <= '0;
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_imm        <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= 2'b00;
        end else if (!i_hold) begin
            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_rs         <= '0;
                r_rt         <= '0;
                r_write_reg  <= '0;
                r_read_data1 <= '0;
                r_read_data2 <= '0;
                r_imm        <= '0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_alu_src    <= 1'b0;
                r_alu_op     <= 2'b00;
            end else begin
                r_valid      <= i_valid;
                r_rs         <= i_Rs;
                r_rt         <= i_Rt;
                r_write_reg  <= i_RegDst ? i_Rd : i_Rt;
                r_read_data1 <= i_Read_data1;
                r_read_data2 <= i_Read_data2;
                r_imm        <= i_Imm;
                // Control of an empty slot must never have side effects in EX
                r_reg_write  <= i_valid & i_RegWrite;
                r_mem_read   <= i_valid & i_MemRead;
                r_mem_write  <= i_valid & i_MemWrite;
                r_mem_to_reg <= i_valid & i_MemtoReg;
                r_alu_src    <= i_valid & i_ALUSrc;
                r_alu_op     <= i_valid ? i_ALUOp : 2'b00;
            end
        end
    end

`ifdef HAZ_STAT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating statistics: stall and flush bubbles, frozen while held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!i_hold) begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (i_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    // Statistics counters not built
`endif

    assign o_valid      = r_valid;
    assign o_Rs         = r_rs;
    assign o_Rt         = r_rt;
    assign o_Write_reg  = r_write_reg;
    assign o_Read_data1 = r_read_data1;
    assign o_Read_data2 = r_read_data2;
    assign o_Imm        = r_imm;
    assign o_RegWrite   = r_reg_write;
    assign o_MemRead    = r_mem_read;
    assign o_MemWrite   = r_mem_write;
    assign o_MemtoReg   = r_mem_to_reg;
    assign o_ALUSrc     = r_alu_src;
    assign o_ALUOp      = r_alu_op;
    assign o_stall      = w_stall;
    assign o_PCWrite    = w_upstream_we;
    assign o_IFIDWrite  = w_upstream_we;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_hazard_reg
// Description : Self-checking bench for id_ex_hazard_reg. A transaction-level
//               model of the EX slot is compared every cycle, plus directed
//               literal expectations for reset, load-use, $0, flush and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_reg;

    localparam int c_SAT = 15;   // counters instantiated 4 bits wide

    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        as;
        logic [1:0]  op;
    } ex_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid, i_uses_rs, i_uses_rt;
    logic [4:0]  i_Rs, i_Rt, i_Rd;
    logic [31:0] i_Read_data1, i_Read_data2, i_Imm;
    logic        i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst;
    logic [1:0]  i_ALUOp;
    logic        i_flush, i_hold;
    logic        o_valid;
    logic [4:0]  o_Rs, o_Rt, o_Write_reg;
    logic [31:0] o_Read_data1, o_Read_data2, o_Imm;
    logic        o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc;
    logic [1:0]  o_ALUOp;
    logic        o_stall, o_PCWrite, o_IFIDWrite;
`ifdef HAZ_STAT_EN
    logic [3:0]  o_stall_cnt, o_flush_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    bit   run    = 0;
    ex_t  m;
    int   ms, mf;
    ex_t  dut_ex;

    id_ex_hazard_reg #(.DW(32), .RW(5), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid),
        .i_Rs(i_Rs), .i_Rt(i_Rt), .i_Rd(i_Rd),
        .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_Read_data1(i_Read_data1), .i_Read_data2(i_Read_data2), .i_Imm(i_Imm),
        .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_MemtoReg(i_MemtoReg), .i_ALUSrc(i_ALUSrc), .i_RegDst(i_RegDst),
        .i_ALUOp(i_ALUOp), .i_flush(i_flush), .i_hold(i_hold),
        .o_valid(o_valid), .o_Rs(o_Rs), .o_Rt(o_Rt), .o_Write_reg(o_Write_reg),
        .o_Read_data1(o_Read_data1), .o_Read_data2(o_Read_data2), .o_Imm(o_Imm),
        .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_MemtoReg(o_MemtoReg), .o_ALUSrc(o_ALUSrc), .o_ALUOp(o_ALUOp),
        .o_stall(o_stall), .o_PCWrite(o_PCWrite), .o_IFIDWrite(o_IFIDWrite)
`ifdef HAZ_STAT_EN
        ,
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_ex = {o_valid, o_Rs, o_Rt, o_Write_reg, o_Read_data1, o_Read_data2,
                     o_Imm, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg,
                     o_ALUSrc, o_ALUOp};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Does the instruction in ID read the destination of a load sitting in EX?
    function automatic bit hazard();
        return m.v && m.mr && (m.wr != 5'd0) && i_valid &&
               ((i_uses_rs && i_Rs == m.wr) || (i_uses_rt && i_Rt == m.wr));
    endfunction

    function automatic bit exp_stall();
        if (i_hold)  return 1'b0;
        if (i_flush) return 1'b0;
        return hazard();
    endfunction

    function automatic bit exp_we();
        if (i_hold)  return 1'b0;
        if (i_flush) return 1'b1;
        return !hazard();
    endfunction

    // Transaction-level model of the EX slot
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m  = '0;
            ms = 0;
            mf = 0;
        end else if (!i_hold) begin
            if (i_flush) begin
                m = '0;
                if (mf < c_SAT) mf++;
            end else if (hazard()) begin
                m = '0;
                if (ms < c_SAT) ms++;
            end else begin
                m.v   = i_valid;
                m.rs  = i_Rs;
                m.rt  = i_Rt;
                m.wr  = i_RegDst ? i_Rd : i_Rt;
                m.d1  = i_Read_data1;
                m.d2  = i_Read_data2;
                m.imm = i_Imm;
                m.rw  = i_valid ? i_RegWrite : 1'b0;
                m.mr  = i_valid ? i_MemRead  : 1'b0;
                m.mw  = i_valid ? i_MemWrite : 1'b0;
                m.m2r = i_valid ? i_MemtoReg : 1'b0;
                m.as  = i_valid ? i_ALUSrc   : 1'b0;
                m.op  = i_valid ? i_ALUOp    : 2'b00;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("ex_slot", dut_ex, m);
            chk("upstream", {o_stall, o_PCWrite, o_IFIDWrite},
                {exp_stall(), exp_we(), exp_we()});
`ifdef HAZ_STAT_EN
            chk("counters", {o_stall_cnt, o_flush_cnt}, {4'(ms), 4'(mf)});
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urs, input logic urt,
                         input logic regdst, input logic mr, input logic rw,
                         input logic [31:0] d1, input logic [31:0] d2);
        i_valid      = v;
        i_Rs         = rs;
        i_Rt         = rt;
        i_Rd         = rd;
        i_uses_rs    = urs;
        i_uses_rt    = urt;
        i_RegDst     = regdst;
        i_MemRead    = mr;
        i_MemtoReg   = mr;
        i_ALUSrc     = mr;
        i_MemWrite   = 1'b0;
        i_RegWrite   = rw;
        i_ALUOp      = mr ? 2'b00 : 2'b10;
        i_Read_data1 = d1;
        i_Read_data2 = d2;
        i_Imm        = d1 + 32'h1000;
    endtask

    task automatic nop();
        instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_hold  = 1'b0;
        i_flush = 1'b0;
        instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5, 32'h6);
        repeat (2) cyc();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_regwrite", o_RegWrite, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_pcwrite", o_PCWrite, 1'b1);
        rst_n = 1'b1;
        run   = 1'b1;

        // Normal pass: add $10, $8, $9
        instr(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11, 32'h22);
        cyc();
        chk("norm_write_reg", o_Write_reg, 5'd10);
        chk("norm_data1", o_Read_data1, 32'h11);
        chk("norm_data2", o_Read_data2, 32'h22);
        chk("norm_valid", o_valid, 1'b1);
        nop();
        #1;
        chk("norm_stall", o_stall, 1'b0);

        // Asynchronous reset mid-cycle
        instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5, 32'h6);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", o_valid, 1'b0);
        chk("async_regwrite", o_RegWrite, 1'b0);
        chk("async_data1", o_Read_data1, 32'h0);
        chk("async_pcwrite", o_PCWrite, 1'b1);
        #2;
        rst_n = 1'b1;

        // Load-use: lw $9 then add $11, $9, $3
        instr(1'b1, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0);
        cyc();
        instr(1'b1, 5'd9, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'haa, 32'hbb);
        #1;
        chk("lu_stall", o_stall, 1'b1);
        chk("lu_pcwrite", o_PCWrite, 1'b0);
        chk("lu_ifidwrite", o_IFIDWrite, 1'b0);
        cyc();
        chk("lu_bubble_valid", o_valid, 1'b0);
        chk("lu_bubble_regwrite", o_RegWrite, 1'b0);
        chk("lu_one_cycle", o_stall, 1'b0);
        cyc();
        chk("lu_add_valid", o_valid, 1'b1);
        chk("lu_add_wr", o_Write_reg, 5'd11);
        chk("lu_add_data1", o_Read_data1, 32'haa);

        // Load to $0 followed by a reader of $0
        instr(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h0);
        cyc();
        instr(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2, 32'h3);
        #1;
        chk("r0_stall", o_stall, 1'b0);
        cyc();

        // Load to $9 followed by an instruction that does not read Rt
        instr(1'b1, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h0);
        cyc();
        instr(1'b1, 5'd5, 5'd9, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2, 32'h3);
        #1;
        chk("unused_rt_stall", o_stall, 1'b0);
        cyc();

        // Back-to-back dependent loads, then a consumer of the second
        instr(1'b1, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h0);
        cyc();
        instr(1'b1, 5'd9, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2, 32'h0);
        #1;
        chk("b2b_stall1", o_stall, 1'b1);
        cyc();
        cyc();
        instr(1'b1, 5'd10, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3, 32'h4);
        #1;
        chk("b2b_stall2", o_stall, 1'b1);
        cyc();
        cyc();

        // Flush with a simultaneous load-use, from fresh counters
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        instr(1'b1, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h0);
        cyc();
        instr(1'b1, 5'd9, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 32'h8);
        i_flush = 1'b1;
        #1;
        chk("flush_stall", o_stall, 1'b0);
        chk("flush_pcwrite", o_PCWrite, 1'b1);
        cyc();
        i_flush = 1'b0;
        chk("flush_valid", o_valid, 1'b0);
`ifdef HAZ_STAT_EN
        chk("flush_cnt", o_flush_cnt, 4'd1);
        chk("flush_stall_cnt", o_stall_cnt, 4'd0);
`endif

        // Hold for three cycles with flush and changing inputs
        instr(1'b1, 5'd6, 5'd7, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h5678);
        cyc();
        i_hold  = 1'b1;
        i_flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr(1'b1, 5'(k + 16), 5'(k + 20), 5'(k + 24), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  32'(k), 32'(k + 1));
            #1;
            chk("hold_pcwrite", o_PCWrite, 1'b0);
            chk("hold_stall", o_stall, 1'b0);
            cyc();
            chk("hold_frozen", {o_valid, o_Write_reg, o_Read_data1, o_Read_data2},
                {1'b1, 5'd14, 32'h1234, 32'h5678});
`ifdef HAZ_STAT_EN
            chk("hold_cnt", o_flush_cnt, 4'd1);
`endif
        end
        i_hold = 1'b0;
        #1;
        chk("release_pcwrite", o_PCWrite, 1'b1);
        cyc();
        chk("release_flush", {o_valid, o_Read_data1}, {1'b0, 32'h0});
`ifdef HAZ_STAT_EN
        chk("release_cnt", o_flush_cnt, 4'd2);
        for (int k = 0; k < 16; k++) cyc();
        chk("flush_cnt_sat", o_flush_cnt, 4'hf);
`endif
        i_flush = 1'b0;
        nop();
        cyc();
        cyc();
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the register file and captures the RF read data, immediate, register specifiers and decoded control for the EX stage. It also contains load-use hazard detection and bubble insertion, and it drives the PC / IF-ID write enables upstream. Branch flush and a downstream hold are handled here.

Parameters:
DW, 32, datapath width (read data, immediate)
RW, 5, register specifier width
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  IF/ID holds a real instruction
i_Rs, i_Rt, i_Rd  in  RW each  register specifiers from decode
i_uses_rs, i_uses_rt  in  1 each  instruction actually reads Rs / Rt
i_Read_data1, i_Read_data2  in  DW each  RF read ports
i_Imm  in  DW  sign-extended immediate
i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst  in  1 each  decoded control
i_ALUOp  in  2  ALU operation class
i_flush  in  1  squash the instruction in ID (taken branch/jump)
i_hold  in  1  downstream stall; freeze ID/EX
o_valid  out  1  EX stage holds a real instruction
o_Rs, o_Rt  out  RW each  registered specifiers (for forwarding)
o_Write_reg  out  RW  registered destination: i_RegDst ? i_Rd : i_Rt
o_Read_data1, o_Read_data2, o_Imm  out  DW each  registered data
o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc  out  1 each  registered control
o_ALUOp  out  2  registered ALU op
o_stall  out  1  load-use hazard detected this cycle (combinational)
o_PCWrite, o_IFIDWrite  out  1 each  upstream write enables (combinational)

Behaviour:
- Reset (async, active-low): all registered outputs go to 0, including o_valid and all control and data. Reset asserted mid-stall clears the bubble state. After reset, o_stall=0 and o_PCWrite=o_IFIDWrite=~i_hold.
- Load-use detect (combinational): lu = o_valid & o_MemRead & (o_Write_reg != 0) & i_valid & ((i_uses_rs & i_Rs==o_Write_reg) | (i_uses_rt & i_Rt==o_Write_reg)). Register 0 never causes a hazard.
- Each rising edge, priority is hold > flush > load-use > normal:
  - hold: ID/EX keeps all values. o_PCWrite=o_IFIDWrite=0. o_stall=0. i_flush is ignored, so upstream keeps it asserted until hold drops.
  - flush: load a bubble (o_valid=0; RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp=0; data and specifiers =0). o_PCWrite=o_IFIDWrite=1. Flush plus lu in the same cycle gives a bubble with o_stall=0.
  - load-use: load a bubble. o_stall=1, o_PCWrite=o_IFIDWrite=0, so the ID instruction re-presents next cycle. The stall lasts exactly one cycle because the bubble clears o_MemRead.
  - normal: capture all inputs. o_valid=i_valid; control is zeroed when i_valid=0. o_PCWrite=o_IFIDWrite=1.
- Latency: 1 cycle from ID inputs to EX outputs. No arithmetic beyond comparators and the RegDst mux.
- Back-to-back loads with dependent consumers each produce one stall. A load followed by an unrelated instruction produces no stall.

Optional Feature:
HAZ_STAT_EN: defined adds o_stall_cnt [CNT_W] and o_flush_cnt [CNT_W].
- o_stall_cnt increments on each load-use bubble; o_flush_cnt increments on each flush bubble.
- Neither counter increments during hold.
- Both saturate at all-ones and reset to 0.
Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive i_rst_n=0 mid-cycle with i_RegWrite=1, i_valid=1 -> all outputs 0 immediately. o_PCWrite=1 with i_hold=0.
- Normal pass: add with Rs=8, Rt=9, Rd=10, RegDst=1, data1=0x11, data2=0x22 -> next edge o_Write_reg=10, o_Read_data1=0x11, o_Read_data2=0x22, o_valid=1, o_stall=0.
- Load-use: lw Rt=9, MemRead=1, RegDst=0, then add using Rs=9 -> o_stall=1 and o_PCWrite=0 for one cycle, bubble in EX (o_RegWrite=0). The add enters EX on the following edge.
- r0 and unused operand: lw to $0 followed by a reader of $0 -> no stall. lw to $9 followed by an instruction with i_uses_rt=0 and Rt=9 -> no stall.
- Flush priority: flush=1 and load-use in the same cycle -> bubble, o_stall=0, o_PCWrite=1. With HAZ_STAT_EN, o_flush_cnt=1 and o_stall_cnt=0.
- Hold: i_hold=1 for 3 cycles with changing inputs and flush=1 -> EX outputs frozen, o_PCWrite=0, counters unchanged. On release the flush takes effect.
